// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: data port, fetch port and the RAM side.
// Suffixes are from the arbiter's point of view; slave = arbiter, master = environment.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DATA_W-1:0] d_rdata_o;
  logic              i_req_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic              i_gnt_o;
  logic              i_rvalid_o;
  logic [DATA_W-1:0] i_rdata_o;
  logic              stall_if_o;
  logic              stall_mem_o;
  logic              ram_en_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [DATA_W-1:0] ram_rdata_i;

  modport slave (
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, i_req_i, i_addr_i, ram_rdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o, i_gnt_o, i_rvalid_o, i_rdata_o,
           stall_if_o, stall_mem_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
  );

  modport master (
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, i_req_i, i_addr_i, ram_rdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o, i_gnt_o, i_rvalid_o, i_rdata_o,
           stall_if_o, stall_mem_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port sync RAM between the fetch port and the data port (data has priority).
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  logic              d_gnt;
  logic              i_gnt;
  logic              fetch_win;
  logic              resp_vld_q, resp_vld_d;
  logic              resp_sel_q, resp_sel_d;
  logic              d_rvalid;
  logic              i_rvalid;
  logic [DATA_W-1:0] d_rdata_q;
  logic [DATA_W-1:0] i_rdata_q;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CLOG_W = $clog2(STARVE_MAX + 1);
  localparam int CNT_W  = (CLOG_W < 3) ? 3 : CLOG_W;

  logic [CNT_W-1:0] starve_q, starve_d;

  assign fetch_win = (starve_q == CNT_W'(STARVE_MAX)) & bus.d_req_i & bus.i_req_i;

  // Counts data grants that overtook a waiting fetch; any fetch grant or idle IF restarts it.
  always_comb begin
    starve_d = starve_q;
    if (i_gnt || !bus.i_req_i) begin
      starve_d = '0;
    end else if (d_gnt) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_max;

  assign fetch_win         = 1'b0;
  assign unused_starve_max = (STARVE_MAX == 0);
`endif

  // Grants are forced low during reset so no RAM access can start.
  assign d_gnt = rst_n & bus.d_req_i & ~fetch_win;
  assign i_gnt = rst_n & bus.i_req_i & (~bus.d_req_i | fetch_win);

  assign bus.d_gnt_o     = d_gnt;
  assign bus.i_gnt_o     = i_gnt;
  assign bus.stall_mem_o = rst_n & bus.d_req_i & ~d_gnt;
  assign bus.stall_if_o  = rst_n & bus.i_req_i & ~i_gnt;

  assign bus.ram_en_o = d_gnt | i_gnt;
  assign bus.ram_we_o = d_gnt & bus.d_we_i;

  always_comb begin
    bus.ram_addr_o  = '0;
    bus.ram_wdata_o = '0;
    if (d_gnt) begin
      bus.ram_addr_o  = bus.d_addr_i;
      bus.ram_wdata_o = bus.d_wdata_i;
    end else if (i_gnt) begin
      bus.ram_addr_o  = bus.i_addr_i;
    end
  end

  assign resp_vld_d = (d_gnt & ~bus.d_we_i) | i_gnt;
  assign resp_sel_d = d_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_vld_q <= 1'b0;
      resp_sel_q <= 1'b0;
    end else begin
      resp_vld_q <= resp_vld_d;
      resp_sel_q <= resp_sel_d;
    end
  end

  assign d_rvalid = resp_vld_q & resp_sel_q;
  assign i_rvalid = resp_vld_q & ~resp_sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_rdata_q <= '0;
      i_rdata_q <= '0;
    end else begin
      if (d_rvalid) d_rdata_q <= bus.ram_rdata_i;
      if (i_rvalid) i_rdata_q <= bus.ram_rdata_i;
    end
  end

  // Fresh RAM data is passed through in the rvalid cycle; the capture register holds it afterwards.
  assign bus.d_rvalid_o = d_rvalid;
  assign bus.i_rvalid_o = i_rvalid;
  assign bus.d_rdata_o  = d_rvalid ? bus.ram_rdata_i : d_rdata_q;
  assign bus.i_rdata_o  = i_rvalid ? bus.ram_rdata_i : i_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic against a reference model.
// Honours ARB_STARVE_GUARD_EN the same way as the design.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(int a);
    if (a == 16) return 32'h0010_0093;
    return 32'hA500_0000 ^ (32'(a) * 32'h0001_9E37);
  endfunction

  // Behavioural single-port synchronous RAM, 4K words indexed by the low address bits.
  logic [31:0] mem [0:4095];
  bit          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
      bus.ram_rdata_i <= '0;
      mem_ready <= 1'b1;
    end else if (bus.ram_en_o) begin
      if (bus.ram_we_o) mem[bus.ram_addr_o[11:0]] <= bus.ram_wdata_o;
      else              bus.ram_rdata_i <= mem[bus.ram_addr_o[11:0]];
    end
  end

  logic [31:0] ref_mem [0:4095];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.d_req_i   = 1'b0;
    bus.d_we_i    = 1'b0;
    bus.d_addr_i  = '0;
    bus.d_wdata_i = '0;
    bus.i_req_i   = 1'b0;
    bus.i_addr_i  = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [7:0] ctrl_vec();
    return {bus.d_gnt_o, bus.i_gnt_o, bus.stall_if_o, bus.stall_mem_o,
            bus.ram_en_o, bus.ram_we_o, bus.d_rvalid_o, bus.i_rvalid_o};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 32'h44; bus.d_wdata_i = 32'h1234;
    bus.i_req_i = 1'b1; bus.i_addr_i = 32'h88;
    #2;
    n_checks++;
    if (ctrl_vec() !== 8'h00) begin
      n_errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl_vec(), 8'h00);
    end
    n_checks++;
    if ({bus.d_rdata_o, bus.i_rdata_o} !== 64'h0) begin
      n_errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.d_rdata_o, bus.i_rdata_o);
    end
    drive_idle();
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if ({ctrl_vec(), bus.ram_addr_o, bus.ram_wdata_o} !== 72'h0) begin
      n_errors++; $display("FAIL idle_outputs: got ctrl=%b addr=%h wdata=%h expected all 0",
                           ctrl_vec(), bus.ram_addr_o, bus.ram_wdata_o);
    end
    tick();
  endtask

  task automatic test_isolated_fetch();
    bus.i_req_i = 1'b1; bus.i_addr_i = 32'h0000_0010;
    @(negedge clk);
    n_checks++;
    if ({bus.i_gnt_o, bus.stall_if_o, bus.ram_en_o, bus.ram_we_o} !== 4'b1010 ||
        bus.ram_addr_o !== 32'h10) begin
      n_errors++; $display("FAIL fetch_grant: got gnt=%b stall=%b en=%b we=%b addr=%h expected 1 0 1 0 00000010",
                           bus.i_gnt_o, bus.stall_if_o, bus.ram_en_o, bus.ram_we_o, bus.ram_addr_o);
    end
    tick();
    bus.i_req_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.i_rvalid_o !== 1'b1 || bus.i_rdata_o !== 32'h0010_0093 || bus.d_rvalid_o !== 1'b0) begin
      n_errors++; $display("FAIL fetch_resp: got iv=%b dv=%b data=%h expected 1 0 00100093",
                           bus.i_rvalid_o, bus.d_rvalid_o, bus.i_rdata_o);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (bus.i_rvalid_o !== 1'b0 || bus.i_rdata_o !== 32'h0010_0093) begin
      n_errors++; $display("FAIL fetch_hold: got iv=%b data=%h expected 0 00100093",
                           bus.i_rvalid_o, bus.i_rdata_o);
    end
    tick();
  endtask

  task automatic test_collision();
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h100;
    bus.i_req_i = 1'b1; bus.i_addr_i = 32'h20;
    @(negedge clk);
    n_checks++;
    if ({bus.d_gnt_o, bus.i_gnt_o, bus.stall_if_o, bus.stall_mem_o} !== 4'b1010 ||
        bus.ram_addr_o !== 32'h100) begin
      n_errors++; $display("FAIL collide_grant: got dg=%b ig=%b sif=%b smem=%b addr=%h expected 1 0 1 0 00000100",
                           bus.d_gnt_o, bus.i_gnt_o, bus.stall_if_o, bus.stall_mem_o, bus.ram_addr_o);
    end
    tick();
    bus.d_req_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.i_gnt_o !== 1'b1 || bus.d_rvalid_o !== 1'b1 || bus.i_rvalid_o !== 1'b0 ||
        bus.d_rdata_o !== init_val(32'h100)) begin
      n_errors++; $display("FAIL collide_data_resp: got ig=%b dv=%b iv=%b data=%h expected 1 1 0 %h",
                           bus.i_gnt_o, bus.d_rvalid_o, bus.i_rvalid_o, bus.d_rdata_o, init_val(32'h100));
    end
    tick();
    bus.i_req_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.i_rvalid_o !== 1'b1 || bus.d_rvalid_o !== 1'b0 || bus.i_rdata_o !== init_val(32'h20) ||
        bus.d_rdata_o !== init_val(32'h100)) begin
      n_errors++; $display("FAIL collide_fetch_resp: got iv=%b dv=%b idata=%h ddata=%h expected 1 0 %h %h",
                           bus.i_rvalid_o, bus.d_rvalid_o, bus.i_rdata_o, bus.d_rdata_o,
                           init_val(32'h20), init_val(32'h100));
    end
    tick();
  endtask

  task automatic test_store_load();
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 32'h40; bus.d_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if ({bus.d_gnt_o, bus.ram_en_o, bus.ram_we_o} !== 3'b111 || bus.ram_wdata_o !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL store_issue: got dg=%b en=%b we=%b wdata=%h expected 1 1 1 deadbeef",
                           bus.d_gnt_o, bus.ram_en_o, bus.ram_we_o, bus.ram_wdata_o);
    end
    ref_mem[12'h040] = 32'hDEAD_BEEF;
    tick();
    bus.d_we_i = 1'b0; bus.d_wdata_i = '0;
    @(negedge clk);
    n_checks++;
    if (bus.d_rvalid_o !== 1'b0 || bus.ram_we_o !== 1'b0) begin
      n_errors++; $display("FAIL store_no_rvalid: got dv=%b we=%b expected 0 0", bus.d_rvalid_o, bus.ram_we_o);
    end
    tick();
    bus.d_req_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.d_rvalid_o !== 1'b1 || bus.d_rdata_o !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL load_after_store: got dv=%b data=%h expected 1 deadbeef",
                           bus.d_rvalid_o, bus.d_rdata_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h100;
    @(negedge clk);
    n_checks++;
    if (bus.d_gnt_o !== 1'b1) begin
      n_errors++; $display("FAIL midread_grant: got %b expected 1", bus.d_gnt_o);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.d_gnt_o, bus.stall_mem_o, bus.ram_en_o} !== 3'b000) begin
      n_errors++; $display("FAIL midread_forced: got dg=%b smem=%b en=%b expected 0 0 0",
                           bus.d_gnt_o, bus.stall_mem_o, bus.ram_en_o);
    end
    bus.d_req_i = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.d_rvalid_o, bus.i_rvalid_o} !== 2'b00 || bus.d_rdata_o !== '0 || bus.i_rdata_o !== '0) begin
        n_errors++; $display("FAIL midread_discard[%0d]: got dv=%b iv=%b d=%h i=%h expected 0 0 0 0",
                             k, bus.d_rvalid_o, bus.i_rvalid_o, bus.d_rdata_o, bus.i_rdata_o);
      end
      tick();
    end
  endtask

  task automatic test_starve();
    bit exp_f;
    do_reset();
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h80;
    bus.i_req_i = 1'b1; bus.i_addr_i = 32'h24;
    for (int k = 0; k < 15; k++) begin
      exp_f = GUARD && ((k % (STARVE_MAX + 1)) == STARVE_MAX);
      @(negedge clk);
      n_checks++;
      if ({bus.d_gnt_o, bus.i_gnt_o, bus.stall_mem_o, bus.stall_if_o} !== {!exp_f, exp_f, exp_f, !exp_f}) begin
        n_errors++; $display("FAIL starve[%0d]: got dg=%b ig=%b smem=%b sif=%b expected %b %b %b %b", k,
                             bus.d_gnt_o, bus.i_gnt_o, bus.stall_mem_o, bus.stall_if_o,
                             !exp_f, exp_f, exp_f, !exp_f);
      end
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic test_random();
    int          owner;        // 0 = no response due, 1 = data, 2 = fetch
    logic [31:0] resp_data;
    logic [31:0] hold_d, hold_i, exp_drd, exp_ird, exp_addr, exp_wdata;
    int          waited;
    bit          i_pend, fw, eg_d, eg_i;
    do_reset();
    owner = 0; resp_data = '0; hold_d = '0; hold_i = '0; waited = 0; i_pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bus.d_req_i   = ($urandom_range(0, 9) < 6);
      bus.d_we_i    = ($urandom_range(0, 2) == 0);
      bus.d_addr_i  = 32'($urandom_range(0, 31)) * 4;
      bus.d_wdata_i = $urandom;
      if (!i_pend) begin
        bus.i_req_i  = ($urandom_range(0, 3) != 0);
        bus.i_addr_i = 32'($urandom_range(0, 31)) * 4;
      end
      fw   = GUARD && waited == STARVE_MAX && bus.d_req_i && bus.i_req_i;
      eg_d = bus.d_req_i && !fw;
      eg_i = bus.i_req_i && !eg_d;
      exp_addr  = eg_d ? bus.d_addr_i : (eg_i ? bus.i_addr_i : 32'h0);
      exp_wdata = eg_d ? bus.d_wdata_i : 32'h0;
      exp_drd   = (owner == 1) ? resp_data : hold_d;
      exp_ird   = (owner == 2) ? resp_data : hold_i;
      @(negedge clk);
      n_checks++;
      if (ctrl_vec() !== {eg_d, eg_i, bus.i_req_i && !eg_i, bus.d_req_i && !eg_d,
                          eg_d || eg_i, eg_d && bus.d_we_i, owner == 1, owner == 2}) begin
        n_errors++; $display("FAIL rand_ctrl[%0d]: got %b expected %b", c, ctrl_vec(),
                             {eg_d, eg_i, bus.i_req_i && !eg_i, bus.d_req_i && !eg_d,
                              eg_d || eg_i, eg_d && bus.d_we_i, owner == 1, owner == 2});
      end
      n_checks++;
      if (bus.ram_addr_o !== exp_addr || bus.ram_wdata_o !== exp_wdata) begin
        n_errors++; $display("FAIL rand_ram[%0d]: got addr=%h wdata=%h expected %h %h", c,
                             bus.ram_addr_o, bus.ram_wdata_o, exp_addr, exp_wdata);
      end
      n_checks++;
      if (bus.d_rdata_o !== exp_drd || bus.i_rdata_o !== exp_ird) begin
        n_errors++; $display("FAIL rand_rdata[%0d]: got d=%h i=%h expected %h %h", c,
                             bus.d_rdata_o, bus.i_rdata_o, exp_drd, exp_ird);
      end
      hold_d = exp_drd;
      hold_i = exp_ird;
      owner  = (eg_d && !bus.d_we_i) ? 1 : (eg_i ? 2 : 0);
      resp_data = ref_mem[exp_addr[11:0]];
      if (eg_d && bus.d_we_i) ref_mem[bus.d_addr_i[11:0]] = bus.d_wdata_i;
      if (eg_i || !bus.i_req_i) waited = 0;
      else if (eg_d)            waited++;
      i_pend = bus.i_req_i && !eg_i;
      tick();
    end
    drive_idle();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
    drive_idle();
    rst_n = 1'b0;
    tick();
    tick();
    test_reset();
    test_isolated_fetch();
    test_collision();
    test_store_load();
    test_reset_mid_read();
    test_starve();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
